// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner for two 0-15 values shown as two decimal digits
// each, with a dead phase between digits and tear-free updates applied only at frame boundaries.
module display_scan_ctrl #(
  parameter int unsigned ON_CYCLES   = 50000,
  parameter int unsigned DEAD_CYCLES = 500,
  parameter bit          LZ_BLANK    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic       upd,
  output logic       upd_ack,
  output logic [0:6] sseg,
  output logic [3:0] an,
  output logic [1:0] digit,
  output logic       frame_tick
);

  localparam int unsigned MaxCycles = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] OnLast   = CntW'(ON_CYCLES - 1);
  localparam logic [CntW-1:0] DeadLast = CntW'((DEAD_CYCLES == 0) ? 0 : DEAD_CYCLES - 1);

  typedef enum logic {StOn, StDead} state_e;

  state_e          state_q, state_d;
  logic [1:0]      digit_q, digit_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      val1_q, val1_d, val2_q, val2_d;
  logic [3:0]      hold1_q, hold1_d, hold2_q, hold2_d;
  logic            pend_q, pend_d;
  logic            ack_q, ack_d;
  logic            boundary;

  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'd0:    code = 7'b0000001;
      4'd1:    code = 7'b1001111;
      4'd2:    code = 7'b0010010;
      4'd3:    code = 7'b0000110;
      4'd4:    code = 7'b1001100;
      4'd5:    code = 7'b0100100;
      4'd6:    code = 7'b0100000;
      4'd7:    code = 7'b0001111;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0000100;
      default: code = 7'b1111111;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StOn;
      digit_q <= 2'd0;
      cnt_q   <= '0;
      val1_q  <= 4'd0;
      val2_q  <= 4'd0;
      hold1_q <= 4'd0;
      hold2_q <= 4'd0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      cnt_q   <= cnt_d;
      val1_q  <= val1_d;
      val2_q  <= val2_d;
      hold1_q <= hold1_d;
      hold2_q <= hold2_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
    end
  end

  // Frame ends on the last clock of digit 3's final phase.
  always_comb begin
    if (DEAD_CYCLES == 0) begin
      boundary = (state_q == StOn) && (digit_q == 2'd3) && (cnt_q == OnLast);
    end else begin
      boundary = (state_q == StDead) && (digit_q == 2'd3) && (cnt_q == DeadLast);
    end
  end

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    cnt_d   = cnt_q + CntW'(1);
    unique case (state_q)
      StOn: begin
        if (cnt_q == OnLast) begin
          cnt_d = '0;
          if (DEAD_CYCLES == 0) begin
            digit_d = digit_q + 2'd1;
          end else begin
            state_d = StDead;
          end
        end
      end
      StDead: begin
        if (cnt_q == DeadLast) begin
          cnt_d   = '0;
          state_d = StOn;
          digit_d = digit_q + 2'd1;
        end
      end
      default: state_d = StOn;
    endcase
  end

  // A live request at the boundary wins over the held one; both merge into one ack.
  always_comb begin
    val1_d  = val1_q;
    val2_d  = val2_q;
    hold1_d = hold1_q;
    hold2_d = hold2_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;
    if (boundary) begin
      if (upd) begin
        val1_d = num1;
        val2_d = num2;
        ack_d  = 1'b1;
      end else if (pend_q) begin
        val1_d = hold1_q;
        val2_d = hold2_q;
        ack_d  = 1'b1;
      end
      pend_d = 1'b0;
    end else if (upd) begin
      hold1_d = num1;
      hold2_d = num2;
      pend_d  = 1'b1;
    end
  end

  logic [3:0] sel_val, ones, nib;
  logic       tens, blank;

  // Odd digit indices carry the tens place.
  always_comb begin
    sel_val = digit_q[1] ? val1_q : val2_q;
    tens    = (sel_val >= 4'd10);
    ones    = tens ? (sel_val - 4'd10) : sel_val;
    nib     = digit_q[0] ? {3'b000, tens} : ones;
    blank   = LZ_BLANK && digit_q[0] && !tens;
  end

  always_comb begin
    if (state_q == StOn) begin
      an   = ~(4'b0001 << digit_q);
      sseg = blank ? 7'b1111111 : seg_code(nib);
    end else begin
      an   = 4'b1111;
      sseg = 7'b1111111;
    end
    digit      = digit_q;
    frame_tick = boundary;
    upd_ack    = ack_q;
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: a frame-position model predicts every output each cycle, with
// hand-computed literal checks pinning the scan timing, update merging and reset behaviour.
module tb_display_scan_ctrl;

  logic       clk, rst, upd;
  logic [3:0] num1, num2;
  logic       upd_ack, frame_tick;
  logic [0:6] sseg;
  logic [3:0] an;
  logic [1:0] digit;

  logic [3:0] zero4;
  logic       upd2, upd_ack2, frame_tick2;
  logic [0:6] sseg2;
  logic [3:0] an2;
  logic [1:0] digit2;

  display_scan_ctrl #(.ON_CYCLES(4), .DEAD_CYCLES(2), .LZ_BLANK(1'b1)) u_dut (
    .clk(clk), .rst(rst), .num1(num1), .num2(num2), .upd(upd), .upd_ack(upd_ack),
    .sseg(sseg), .an(an), .digit(digit), .frame_tick(frame_tick)
  );

  display_scan_ctrl #(.ON_CYCLES(4), .DEAD_CYCLES(0), .LZ_BLANK(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .num1(zero4), .num2(zero4), .upd(upd2), .upd_ack(upd_ack2),
    .sseg(sseg2), .an(an2), .digit(digit2), .frame_tick(frame_tick2)
  );

  int vectors = 0;
  int errs    = 0;
  int tn      = 0;
  logic [6:0] seg_tab [10];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s tn=%0d got=%0h exp=%0h", name, tn, got, exp);
    end
  endtask

  // Model: position in the frame is plain cycle arithmetic since reset release.
  bit   armed = 1'b0;
  int   t = 0, t2 = 0;
  int   mv1 = 0, mv2 = 0, mh1 = 0, mh2 = 0;
  bit   mpend = 1'b0, mack = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      armed <= 1'b1;
      t <= 0; t2 <= 0;
      mv1 <= 0; mv2 <= 0; mh1 <= 0; mh2 <= 0;
      mpend <= 1'b0; mack <= 1'b0;
    end else begin
      if (t % 24 == 23) begin
        mack <= upd | mpend;
        if (upd) begin
          mv1 <= int'(num1); mv2 <= int'(num2);
        end else if (mpend) begin
          mv1 <= mh1; mv2 <= mh2;
        end
        mpend <= 1'b0;
      end else begin
        mack <= 1'b0;
        if (upd) begin
          mh1 <= int'(num1); mh2 <= int'(num2); mpend <= 1'b1;
        end
      end
      t  <= t + 1;
      t2 <= t2 + 1;
    end
  end

  function automatic logic [6:0] exp_seg(input int d, input int v1, input int v2, input bit lz);
    int v;
    v = (d >= 2) ? v1 : v2;
    if (d % 2 == 1) begin
      if (lz && (v / 10 == 0)) return 7'b1111111;
      return seg_tab[v / 10];
    end
    return seg_tab[v % 10];
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      int p, d, p2, d2;
      bit on;
      logic [3:0] ea, ea2;
      p  = t % 24;
      d  = p / 6;
      on = (p % 6) < 4;
      ea = on ? ~(4'b0001 << d) : 4'b1111;
      check("an", 32'(an), 32'(ea));
      check("sseg", 32'(sseg), on ? 32'(exp_seg(d, mv1, mv2, 1'b1)) : 32'h7f);
      check("digit", 32'(digit), 32'(d));
      check("frame_tick", 32'(frame_tick), 32'(p == 23));
      check("upd_ack", 32'(upd_ack), 32'(mack));
      p2  = t2 % 16;
      d2  = p2 / 4;
      ea2 = ~(4'b0001 << d2);
      check("an2_never_off", 32'(an2 == 4'b1111), 32'd0);
      check("an2", 32'(an2), 32'(ea2));
      check("sseg2", 32'(sseg2), 32'(exp_seg(d2, 0, 0, 1'b0)));
      check("frame_tick2", 32'(frame_tick2), 32'(p2 == 15));
      check("upd_ack2", 32'(upd_ack2), 32'd0);
    end
  end

  task automatic go_to(input int n);
    while (tn < n) begin
      @(negedge clk);
      tn++;
    end
  endtask

  initial begin
    seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
    seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
    seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0000100;
    zero4 = 4'd0; upd2 = 1'b0;
    rst = 1'b1; upd = 1'b0; num1 = 4'd0; num2 = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tn = 0;
    check("lit_reset_an", 32'(an), 32'b1110);
    check("lit_reset_sseg", 32'(sseg), 32'b0000001);
    rst = 1'b0;

    // Scan timing after release
    go_to(3);  check("lit_on_end_an", 32'(an), 32'b1110);
    go_to(4);  check("lit_dead_an", 32'(an), 32'b1111);
               check("lit_dead_sseg", 32'(sseg), 32'b1111111);
    go_to(5);  check("lit_dead2_an", 32'(an), 32'b1111);
    go_to(6);  check("lit_d1_an", 32'(an), 32'b1101);
    go_to(22); check("lit_pre_tick", 32'(frame_tick), 32'd0);
    go_to(23); check("lit_tick", 32'(frame_tick), 32'd1);

    // Mid-frame update of 5 / 15
    go_to(30); upd = 1'b1; num1 = 4'd5; num2 = 4'd15;
    go_to(31); upd = 1'b0; num1 = 4'd0; num2 = 4'd0;
    go_to(36); check("lit_no_tear_d2", 32'(sseg), 32'b0000001);
    go_to(47); check("lit_tick2", 32'(frame_tick), 32'd1);
               check("lit_no_ack_yet", 32'(upd_ack), 32'd0);
    go_to(48); check("lit_ack", 32'(upd_ack), 32'd1);
               check("lit_b_d0", 32'(sseg), 32'b0100100);
    go_to(49); check("lit_ack_once", 32'(upd_ack), 32'd0);
    go_to(54); check("lit_b_d1", 32'(sseg), 32'b1001111);
    go_to(60); check("lit_b_d2", 32'(sseg), 32'b0100100);
    go_to(66); check("lit_b_d3", 32'(sseg), 32'b1111111);
               check("lit_b_d3_an", 32'(an), 32'b0111);

    // Update on the boundary clock: 12 / 3
    go_to(71); upd = 1'b1; num1 = 4'd12; num2 = 4'd3;
    go_to(72); upd = 1'b0;
               check("lit_c_ack", 32'(upd_ack), 32'd1);
               check("lit_c_d0", 32'(sseg), 32'b0000110);
    go_to(73); check("lit_c_ack_once", 32'(upd_ack), 32'd0);
    go_to(78); check("lit_c_d1", 32'(sseg), 32'b1111111);
    go_to(84); check("lit_c_d2", 32'(sseg), 32'b0010010);
    go_to(90); check("lit_c_d3", 32'(sseg), 32'b1001111);
    go_to(96); check("lit_c_no_reack", 32'(upd_ack), 32'd0);

    // Two requests merge into one load and one ack
    go_to(100); upd = 1'b1; num1 = 4'd1; num2 = 4'd0;
    go_to(101); upd = 1'b0;
    go_to(102); upd = 1'b1; num1 = 4'd9;
    go_to(103); upd = 1'b0;
    go_to(120); check("lit_d_ack", 32'(upd_ack), 32'd1);
    go_to(121); check("lit_d_ack_once", 32'(upd_ack), 32'd0);
    go_to(132); check("lit_d_d2", 32'(sseg), 32'b0000100);

    // Reset during a dead phase with a request pending
    go_to(150); upd = 1'b1; num1 = 4'd7; num2 = 4'd7;
    go_to(151); upd = 1'b0;
    go_to(154); check("lit_e_dead", 32'(an), 32'b1111);
                rst = 1'b1;
    go_to(155); check("lit_e_an", 32'(an), 32'b1110);
                check("lit_e_sseg", 32'(sseg), 32'b0000001);
                rst = 1'b0;
    go_to(167); check("lit_e_d2", 32'(sseg), 32'b0000001);
    go_to(179); check("lit_e_no_ack", 32'(upd_ack), 32'd0);
    go_to(185);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter ON_CYCLES, default 50000: clocks each digit is driven per visit; legal range >= 1.
REQ-002 Parameter DEAD_CYCLES, default 500: all-anodes-off clocks after each digit; 0 means no dead phase.
REQ-003 Parameter LZ_BLANK, default 1: when 1, a tens digit equal to 0 is shown blank.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 num1  in  4  binary value 0-15 for digits 3 (tens) and 2 (ones).
REQ-007 num2  in  4  binary value 0-15 for digits 1 (tens) and 0 (ones).
REQ-008 upd  in  1  update request; sampled every clock.
REQ-009 upd_ack  out  1  one-cycle pulse: the requested values are now on display.
REQ-010 sseg  out  [0:6]  segments a..g (sseg[0]=a), active-low.
REQ-011 an  out  4  digit anodes, active-low, an[i] selects digit i.
REQ-012 digit  out  2  index of the digit currently scanned.
REQ-013 frame_tick  out  1  one-cycle pulse on the frame-boundary cycle.

Function
REQ-014 FSM states: S_ON and S_DEAD; counter cnt is sized for max(ON_CYCLES, DEAD_CYCLES).
REQ-015 S_ON: an = ~(1<<digit); sseg = code of the selected nibble; after ON_CYCLES clocks go to S_DEAD with cnt=0 (to S_ON of next digit if DEAD_CYCLES=0).
REQ-016 S_DEAD: an=4'b1111, sseg=7'b1111111; after DEAD_CYCLES clocks go to S_ON with digit=digit+1 mod 4 and cnt=0.
REQ-017 Scan order 0,1,2,3,0...; frame length = 4*(ON_CYCLES+DEAD_CYCLES) clocks.
REQ-018 Frame boundary = last clock of digit 3's final phase (S_DEAD, or S_ON if DEAD_CYCLES=0); frame_tick=1 only then.
REQ-019 Displayed registers val1/val2 change only at a frame boundary (no mid-frame tearing).
REQ-020 Split: tens = (val>=10) ? 1 : 0; ones = (val>=10) ? val-10 : val; digit3/2 from val1, digit1/0 from val2.
REQ-021 Codes (active-low a..g): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100.
REQ-022 LZ_BLANK=1 and tens=0: sseg=1111111 while that anode remains driven.
REQ-023 upd on a non-boundary clock: num1/num2 captured into hold registers, pending set.
REQ-024 upd while pending: hold overwritten; requests merge; only one upd_ack issued.
REQ-025 At boundary with upd=1: val1/val2 load num1/num2 directly; pending cleared.
REQ-026 At boundary with upd=0 and pending=1: val1/val2 load hold; pending cleared.
REQ-027 upd_ack pulses high for exactly the clock after any load per REQ-025/026; otherwise 0.
REQ-028 Outputs sseg, an, digit, frame_tick are decoded from registered state only; no input-to-output combinational path.

Reset
REQ-029 rst=1 at an edge: state S_ON, digit=0, cnt=0, val1=val2=0, hold=0, pending=0, upd_ack=0.
REQ-030 During/after reset: an=4'b1110, sseg=0000001, digit=0, frame_tick=0; reset mid-operation discards any pending request without ack.

Verification (ON_CYCLES=4, DEAD_CYCLES=2 unless noted)
REQ-031 Release rst -> an=1110, sseg=0000001 for 4 clks, an=1111 for 2 clks, then an=1101; frame_tick every 24 clks.
REQ-032 upd=1 one clk mid-frame with num1=5, num2=15 -> display unchanged until frame_tick; upd_ack next clk; then digit0=0100100, digit1=1001111, digit2=0100100, digit3=1111111.
REQ-033 upd on boundary clk with num1=12, num2=3 -> applied that boundary; digit3=1001111, digit2=0010010, digit1 blank, digit0=0000110; one ack.
REQ-034 Two upd pulses in one frame (num1=1 then 9) -> digit2 shows 9 after boundary; exactly one upd_ack.
REQ-035 rst asserted during S_DEAD with pending set -> next clk an=1110, sseg=0000001; no upd_ack at next boundary.
REQ-036 DEAD_CYCLES=0, LZ_BLANK=0, num1=num2=0 -> an never 1111, frame 16 clks, tens digits show 0000001.
